// File: rtl/dqpsk_pkg.sv
// Shared types, defaults and lookup helpers for the DQPSK modulator.
package dqpsk_pkg;

    localparam int DEF_SPS   = 8;
    localparam int DEF_NCO_W = 15;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Gray-coded dibit to quarter-turn phase increment.
    function automatic logic [1:0] gray_inc(input logic [1:0] dibit);
        logic [1:0] d;
        unique case (dibit)
            2'b00: d = 2'd0;
            2'b01: d = 2'd1;
            2'b11: d = 2'd2;
            2'b10: d = 2'd3;
        endcase
        return d;
    endfunction

    // Phase state to {I positive, Q positive}.
    function automatic logic [1:0] phase_iq(input logic [1:0] p);
        logic [1:0] iq;
        unique case (p)
            2'd0: iq = 2'b11;
            2'd1: iq = 2'b01;
            2'd2: iq = 2'b00;
            2'd3: iq = 2'b10;
        endcase
        return iq;
    endfunction

endpackage

// File: rtl/dqpsk_diff_enc.sv
// Serial-to-dibit packer, bit handshake and differential phase state.
module dqpsk_diff_enc
    import dqpsk_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clken,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    input  logic       consume,
    output logic       pending,
    output logic [1:0] p,
    output logic [1:0] p_new
);

    logic       hold;
    logic       half;
    logic [1:0] dibit;
    logic       accept;

    assign bit_ready = clken & ~pending;
    assign accept    = bit_valid & bit_ready;
    assign p_new     = p + gray_inc(dibit);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold    <= 1'b0;
            half    <= 1'b0;
            dibit   <= 2'b00;
            pending <= 1'b0;
            p       <= 2'd0;
        end else if (clken) begin
            if (consume) begin
                p       <= p_new;
                pending <= 1'b0;
            end
            if (accept) begin
                if (!half) begin
                    hold <= bit_in;
                    half <= 1'b1;
                end else begin
                    dibit   <= {hold, bit_in};
                    half    <= 1'b0;
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dqpsk_mod.sv
// DQPSK modulator: symbol timing FSM and I*cos - Q*sin carrier mixer.
module dqpsk_mod
    import dqpsk_pkg::*;
#(
    parameter int SPS   = DEF_SPS,
    parameter int NCO_W = DEF_NCO_W,
    parameter int OUT_W = NCO_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clken,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic [NCO_W-1:0] nco_cos,
    input  logic [NCO_W-1:0] nco_sin,
    input  logic             nco_valid,
    output logic [OUT_W-1:0] mod_out,
    output logic             mod_valid,
    output logic             sym_strobe,
    output logic             underflow
);

    localparam int CNT_W = (SPS > 2) ? $clog2(SPS) : 1;
    localparam int W     = OUT_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);
    localparam logic signed [W-1:0] MAXV = W'((2 ** (OUT_W - 1)) - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             ev;
    logic             consume;
    logic             pending;
    logic             use_new;
    logic             zero_out;
    logic             strobe_n;
    logic             uf_n;
    logic [1:0]       p;
    logic [1:0]       p_new;
    logic [1:0]       iq;

    logic signed [NCO_W-1:0] cos_s;
    logic signed [NCO_W-1:0] sin_s;
    logic signed [W-1:0]     ce;
    logic signed [W-1:0]     se;
    logic signed [W-1:0]     tc;
    logic signed [W-1:0]     ts;
    logic signed [W-1:0]     sum;
    logic [OUT_W-1:0]        mixed;

    dqpsk_diff_enc u_enc (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .consume   (consume),
        .pending   (pending),
        .p         (p),
        .p_new     (p_new)
    );

    assign ev = clken & nco_valid;

    // cnt is the index, within its symbol, of the sample being emitted.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        consume  = 1'b0;
        use_new  = 1'b0;
        zero_out = 1'b0;
        strobe_n = 1'b0;
        uf_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (ev) begin
                    if (pending) begin
                        consume  = 1'b1;
                        use_new  = 1'b1;
                        strobe_n = 1'b1;
                        cnt_n    = CNT_W'(1);
                        state_n  = RUN;
                    end else begin
                        zero_out = 1'b1;
                    end
                end
            end
            RUN: begin
                if (ev) begin
                    strobe_n = (cnt == '0);
                    if (cnt == LAST) begin
                        cnt_n = '0;
                        if (pending) begin
                            consume = 1'b1;
                        end else begin
                            uf_n    = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    assign iq    = phase_iq(use_new ? p_new : p);
    assign cos_s = nco_cos;
    assign sin_s = nco_sin;
    assign ce    = cos_s;
    assign se    = sin_s;
    assign tc    = iq[1] ? ce : -ce;
    assign ts    = iq[0] ? -se : se;
    assign sum   = tc + ts;
    assign mixed = (sum > MAXV) ? MAXV[OUT_W-1:0] : sum[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            mod_out    <= '0;
            mod_valid  <= 1'b0;
            sym_strobe <= 1'b0;
            underflow  <= 1'b0;
        end else if (clken) begin
            state      <= state_n;
            cnt        <= cnt_n;
            mod_valid  <= nco_valid;
            sym_strobe <= strobe_n;
            underflow  <= uf_n;
            if (nco_valid) begin
                mod_out <= zero_out ? '0 : mixed;
            end
        end
    end

endmodule

// File: tb/tb_dqpsk_mod.sv
// Scoreboard bench for dqpsk_mod against a symbol-level reference model.
module tb_dqpsk_mod;

    localparam int SPS   = 8;
    localparam int NCO_W = 15;
    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clken;
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic [NCO_W-1:0] nco_cos;
    logic [NCO_W-1:0] nco_sin;
    logic             nco_valid;
    logic [OUT_W-1:0] mod_out;
    logic             mod_valid;
    logic             sym_strobe;
    logic             underflow;

    always #5 clk = ~clk;

    dqpsk_mod #(.SPS(SPS), .NCO_W(NCO_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clken      (clken),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .nco_cos    (nco_cos),
        .nco_sin    (nco_sin),
        .nco_valid  (nco_valid),
        .mod_out    (mod_out),
        .mod_valid  (mod_valid),
        .sym_strobe (sym_strobe),
        .underflow  (underflow)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // dibit value -> quarter turns; also its own inverse
    int gray_tab[4] = '{0, 1, 3, 2};

    int   ev_cos[$];
    int   ev_sin[$];
    int   sym_q[$];
    int   m_p      = 0;
    logic m_half   = 1'b0;
    logic m_hold   = 1'b0;
    logic e_rst    = 1'b1;
    logic e_ce     = 1'b0;
    logic exp_busy = 1'b0;
    int   remaining = 0;
    int   cur_p     = 0;
    int   n_uf      = 0;
    int   n_sym     = 0;
    int   n_idle0   = 0;
    int   prev      = 0;
    int   plan_p    = 0;
    bit   rnd_mode  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_mix(input int ph, input int c, input int s);
        int i_s;
        int q_s;
        int v;
        i_s = (ph == 0 || ph == 3) ? 1 : -1;
        q_s = (ph < 2) ? 1 : -1;
        v = i_s * c - q_s * s;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    // Edge observer: records sample events and builds expected symbols.
    always @(posedge clk) begin
        e_rst    = !reset_n;
        e_ce     = clken;
        exp_busy = 1'b0;
        if (!reset_n) begin
            ev_cos.delete();
            ev_sin.delete();
            sym_q.delete();
            m_p       = 0;
            m_half    = 1'b0;
            remaining = 0;
        end else if (clken) begin
            if (nco_valid) begin
                ev_cos.push_back(int'($signed(nco_cos)));
                ev_sin.push_back(int'($signed(nco_sin)));
            end
            if (bit_valid && bit_ready) begin
                if (!m_half) begin
                    m_hold = bit_in;
                    m_half = 1'b1;
                end else begin
                    m_p = (m_p + gray_tab[{m_hold, bit_in}]) % 4;
                    sym_q.push_back(m_p);
                    m_half   = 1'b0;
                    exp_busy = 1'b1;
                end
            end
        end
    end

    // Monitor: compares every registered output against the scoreboard.
    always @(negedge clk) begin
        int c;
        int s;
        int cur;
        cur = int'({mod_out, mod_valid, sym_strobe, underflow});
        c = 0;
        s = 0;
        if (e_rst) begin
            check("rst_outputs", cur, 0);
            check("rst_ready", int'(bit_ready), int'(clken));
        end else if (!e_ce) begin
            check("freeze", cur, prev);
        end else begin
            if (exp_busy) check("ready_drop", int'(bit_ready), 0);
            if (mod_valid) begin
                if (ev_cos.size() == 0) begin
                    check("event_avail", 0, 1);
                end else begin
                    c = ev_cos.pop_front();
                    s = ev_sin.pop_front();
                end
                if (sym_strobe) begin
                    n_sym++;
                    check("sym_len", remaining, 0);
                    if (sym_q.size() == 0) begin
                        check("sym_avail", 0, 1);
                    end else begin
                        cur_p     = sym_q.pop_front();
                        remaining = SPS;
                    end
                end
                if (remaining > 0) begin
                    check("mod_out", int'($signed(mod_out)), ref_mix(cur_p, c, s));
                    if (underflow) begin
                        n_uf++;
                        check("uf_at_end", remaining, 1);
                    end
                    remaining--;
                end else begin
                    n_idle0++;
                    check("idle_out", int'($signed(mod_out)), 0);
                    check("idle_uf", int'(underflow), 0);
                end
            end else begin
                check("novalid_flags", int'({sym_strobe, underflow}), 0);
            end
        end
        prev = cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            clken     = ($urandom_range(0, 9) != 0);
            nco_valid = ($urandom_range(0, 3) != 0);
            nco_cos   = NCO_W'($urandom);
            nco_sin   = NCO_W'($urandom);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        logic ok;
        int t;
        t = 0;
        bit_in    = b;
        bit_valid = 1'b1;
        forever begin
            #1;
            ok = bit_ready;
            tick();
            if (ok) break;
            t++;
            if (t > 2000) begin
                check("ready_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic send_dibit(input logic [1:0] d);
        send_bit(d[1]);
        send_bit(d[0]);
        plan_p = (plan_p + gray_tab[d]) % 4;
    endtask

    task automatic send_phase(input int target);
        int d;
        d = (target - plan_p + 4) % 4;
        send_dibit(2'(gray_tab[d]));
    endtask

    task automatic drain(input int max);
        bit_valid = 1'b0;
        for (int t = 0; t < max; t++) begin
            if (sym_q.size() == 0 && remaining == 0) break;
            tick();
        end
        check("drain", remaining + sym_q.size(), 0);
        ticks(3);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        plan_p  = 0;
    endtask

    initial begin
        int uf0;
        int sy0;
        int id0;
        reset_n   = 1'b0;
        clken     = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        nco_valid = 1'b1;
        nco_cos   = NCO_W'(16000);
        nco_sin   = '0;

        // dibits 00,01,11,10 on a pure cosine carrier
        do_reset();
        uf0 = n_uf;
        sy0 = n_sym;
        send_dibit(2'b00);
        send_dibit(2'b01);
        send_dibit(2'b11);
        send_dibit(2'b10);
        drain(200);
        check("t1_syms", n_sym - sy0, 4);
        check("t1_uf", n_uf - uf0, 1);

        // single symbol then underflow and idle zeros
        nco_cos = '0;
        nco_sin = NCO_W'(10000);
        do_reset();
        uf0 = n_uf;
        send_dibit(2'b00);
        drain(100);
        id0 = n_idle0;
        ticks(4);
        check("t2_uf", n_uf - uf0, 1);
        check("t2_idle", n_idle0 - id0, 4);

        // back-to-back random dibits must stay contiguous
        nco_cos = NCO_W'($urandom);
        nco_sin = NCO_W'($urandom);
        do_reset();
        uf0 = n_uf;
        sy0 = n_sym;
        for (int i = 0; i < 6; i++) send_dibit(2'($urandom));
        drain(300);
        check("t3_syms", n_sym - sy0, 6);
        check("t3_uf", n_uf - uf0, 1);

        // random clken / nco_valid gating and bit gaps
        sy0 = n_sym;
        rnd_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_dibit(2'($urandom));
            bit_valid = 1'b0;
            ticks($urandom_range(0, 12));
        end
        drain(5000);
        rnd_mode  = 1'b0;
        clken     = 1'b1;
        nco_valid = 1'b1;
        check("t4_syms", n_sym - sy0, 20);

        // saturation corner: both carriers at full negative scale
        nco_cos = NCO_W'(-16384);
        nco_sin = NCO_W'(-16384);
        do_reset();
        sy0 = n_sym;
        send_phase(2);
        send_phase(3);
        send_phase(1);
        drain(200);
        check("t5_syms", n_sym - sy0, 3);

        // reset mid-symbol with a dibit pending
        nco_cos = NCO_W'(16000);
        nco_sin = '0;
        do_reset();
        send_dibit(2'b00);
        send_dibit(2'b11);
        bit_valid = 1'b0;
        ticks(2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        plan_p  = 0;
        check("t6_ready", int'(bit_ready), 1);
        sy0 = n_sym;
        send_dibit(2'b01);
        drain(100);
        check("t6_syms", n_sym - sy0, 1);
        check("t6_last_out", int'($signed(mod_out)), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
